// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package axis_fifo_pkg;
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_CNT_W = 8;
endpackage

// File: rtl/axis_fifo_wr_arb_rr_pick.sv
// Combinational round-robin select: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic            o_found
);
    int unsigned w_sum;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_onehot = '0;
        o_found  = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = 32'(i_ptr) + k;
            if (w_sum >= NREQ) w_sum = w_sum - NREQ;
            w_idx = PW'(w_sum);
            if (!o_found && i_req[w_idx]) begin
                o_onehot[w_idx] = 1'b1;
                o_found         = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axis_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between NREQ AXI4-Stream
// inputs; a grant is held until tlast or the beat cap.
module axis_fifo_wr_arb
    import axis_fifo_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DLEN     = 32,
    parameter int unsigned MAXBURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      s_tvalid,
    output logic [NREQ-1:0]      s_tready,
    input  logic [NREQ*DLEN-1:0] s_tdata,
    input  logic [NREQ-1:0]      s_tlast,
    output logic                 o_wen,
    output logic [DLEN-1:0]      o_wdata,
    input  logic                 i_wfull,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);
    localparam int unsigned PW = $clog2(NREQ);

    arb_state_e           r_state, w_state_nxt;
    logic [NREQ-1:0]      r_gnt, w_gnt_nxt;
    logic [PW-1:0]        r_ptr, w_ptr_nxt;
    logic [ARB_CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [NREQ-1:0] w_pick;
    logic            w_found;
    logic            w_locked, w_tvalid_g, w_tlast_g, w_beat, w_release;
    logic [PW-1:0]   w_gidx, w_ptr_inc;
    logic [DLEN-1:0] w_wdata;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req    (s_tvalid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick),
        .o_found  (w_found)
    );

    // r_gnt is all-zero in IDLE, so the per-grant selects collapse to 0 there
    assign w_locked   = (r_state == ARB_LOCKED);
    assign w_tvalid_g = |(s_tvalid & r_gnt);
    assign w_tlast_g  = |(s_tlast & r_gnt);
    assign w_beat     = w_locked & w_tvalid_g & ~i_wfull;
    assign w_release  = w_beat & (w_tlast_g | (r_cnt == ARB_CNT_W'(MAXBURST - 1)));

    always_comb begin
        w_gidx  = '0;
        w_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_wdata = w_wdata | (s_tdata[i*DLEN +: DLEN] & {DLEN{r_gnt[i]}});
            if (r_gnt[i]) w_gidx = PW'(i);
        end
    end

    assign w_ptr_inc = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

    assign s_tready = (w_locked && !i_wfull) ? r_gnt : '0;
    assign o_wen    = w_beat;
    assign o_wdata  = w_wdata;
    assign o_grant  = r_gnt;
    assign o_busy   = w_locked;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (w_release) begin
                    w_state_nxt = ARB_IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_cnt_nxt   = '0;
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_axis_fifo_wr_arb.sv
// Directed bench for axis_fifo_wr_arb (NREQ=4, DLEN=32, MAXBURST=4).
module tb_axis_fifo_wr_arb;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   s_tvalid, s_tready, s_tlast, o_grant;
    logic [127:0] s_tdata;
    logic         o_wen, i_wfull, o_busy;
    logic [31:0]  o_wdata;

    axis_fifo_wr_arb #(.NREQ(4), .DLEN(32), .MAXBURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .o_wen    (o_wen),
        .o_wdata  (o_wdata),
        .i_wfull  (i_wfull),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    // Producer model: rem beats left, plen = packet length (0 = no tlast)
    int unsigned rem [4];
    int unsigned plen[4];
    int unsigned sent[4];
    logic [3:0]  gap;

    logic        smp_wen, smp_busy;
    logic [31:0] smp_wdata;
    logic [3:0]  smp_grant, smp_tready, hs;
    int          cyc;
    logic [31:0] log_data[$];
    int          log_cyc[$];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] beat(input int r, input int s);
        return {8'(r), 24'(s)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i] = (rem[i] != 0) && !gap[i];
            s_tdata[i*32 +: 32] = beat(i, int'(sent[i]));
            s_tlast[i] = (plen[i] != 0) && (((sent[i] + 1) % plen[i]) == 0);
        end
    endtask

    task automatic load(input int r, input int unsigned n, input int unsigned pl);
        rem[r]  = n;
        plen[r] = pl;
        sent[r] = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        smp_wen    = o_wen;
        smp_wdata  = o_wdata;
        smp_grant  = o_grant;
        smp_tready = s_tready;
        smp_busy   = o_busy;
        hs         = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        cyc++;
        if (smp_wen) begin
            log_data.push_back(smp_wdata);
            log_cyc.push_back(cyc);
        end
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                rem[i]--;
                sent[i]++;
            end
        end
        drive();
    endtask

    task automatic run_until(input int n, input int budget);
        int g;
        g = 0;
        while (log_data.size() < n && g < budget) begin
            tick();
            g++;
        end
    endtask

    initial begin
        int exp_req[16];
        int exp_seq[16];
        exp_req = '{0,0,1,1,2,2,2,2,3,3,2,2,2,2,2,2};
        exp_seq = '{0,1,0,1,0,1,2,3,0,1,4,5,6,7,8,9};
        cyc = 0;
        rst = 1'b1;
        i_wfull = 1'b0;
        gap = '0;
        for (int i = 0; i < 4; i++) load(i, 2, 2);
        drive();

        // Reset held with every requester valid
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_wen", 32'(smp_wen), 32'd0);
            chk("rst_grant", 32'(smp_grant), 32'd0);
            chk("rst_tready", 32'(smp_tready), 32'd0);
        end
        rst = 1'b0;
        log_data.delete();
        log_cyc.delete();
        tick();
        chk("post_rst_idle_grant", 32'(smp_grant), 32'd0);
        chk("post_rst_idle_busy", 32'(smp_busy), 32'd0);
        tick();
        chk("first_grant", 32'(smp_grant), 32'b0001);
        chk("first_busy", 32'(smp_busy), 32'd1);
        chk("first_wen", 32'(smp_wen), 32'd1);
        chk("first_wdata", smp_wdata, beat(0, 0));

        // Round robin: four 2-beat packets, one idle bubble between packets
        run_until(8, 40);
        chk("rr_count", 32'(log_data.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < log_data.size()) begin
                chk("rr_data", log_data[k], beat(k / 2, k % 2));
                chk("rr_spacing", 32'(log_cyc[k] - log_cyc[0]), 32'(k + k / 2));
            end
        end
        tick();
        chk("rr_done_idle", 32'(smp_busy), 32'd0);

        // Beat cap: requester 2 has a 10-beat packet, others 2-beat packets
        log_data.delete();
        log_cyc.delete();
        load(0, 2, 2);
        load(1, 2, 2);
        load(2, 10, 10);
        load(3, 2, 2);
        drive();
        run_until(16, 80);
        chk("cap_count", 32'(log_data.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < log_data.size()) chk("cap_order", log_data[k], beat(exp_req[k], exp_seq[k]));
        end
        tick();
        tick();

        // Wrap: pointer now 3, only requester 1 asks; gap mid-packet holds grant
        load(1, 3, 3);
        drive();
        tick();
        chk("wrap_idle", 32'(smp_grant), 32'd0);
        tick();
        chk("wrap_grant", 32'(smp_grant), 32'b0010);
        chk("wrap_beat0", smp_wdata, beat(1, 0));
        gap[1] = 1'b1;
        drive();
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("gap_wen", 32'(smp_wen), 32'd0);
            chk("gap_grant", 32'(smp_grant), 32'b0010);
        end
        gap[1] = 1'b0;
        drive();
        tick();
        chk("gap_beat1_wen", 32'(smp_wen), 32'd1);
        chk("gap_beat1", smp_wdata, beat(1, 1));
        tick();
        chk("gap_beat2", smp_wdata, beat(1, 2));
        tick();
        chk("gap_release", 32'(smp_grant), 32'd0);

        // Full stall: 5 cycles of i_wfull after two beats of a 5-beat packet
        log_data.delete();
        log_cyc.delete();
        load(2, 5, 5);
        drive();
        tick();
        tick();
        tick();
        i_wfull = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_wen", 32'(smp_wen), 32'd0);
            chk("stall_tready", 32'(smp_tready), 32'd0);
            chk("stall_grant", 32'(smp_grant), 32'b0100);
        end
        i_wfull = 1'b0;
        drive();
        run_until(5, 20);
        chk("stall_count", 32'(log_data.size()), 32'd5);
        if (log_data.size() == 5) begin
            for (int k = 0; k < 5; k++) chk("stall_data", log_data[k], beat(2, k));
            chk("stall_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
            chk("stall_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'd6);
            chk("stall_cap_hold", 32'(log_cyc[3] - log_cyc[2]), 32'd1);
            chk("stall_cap_bubble", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
        end
        tick();
        tick();

        // Reset on beat 3 of a 6-beat packet from requester 2 (pointer is 3)
        load(2, 6, 6);
        drive();
        tick();
        tick();
        chk("mid_beat0", smp_wdata, beat(2, 0));
        tick();
        chk("mid_beat1", smp_wdata, beat(2, 1));
        rst = 1'b1;
        drive();
        tick();
        chk("mid_rst_beat2", smp_wdata, beat(2, 2));
        rst = 1'b0;
        load(0, 2, 2);
        load(3, 2, 2);
        drive();
        tick();
        chk("mid_after_busy", 32'(smp_busy), 32'd0);
        chk("mid_after_grant", 32'(smp_grant), 32'd0);
        chk("mid_after_wen", 32'(smp_wen), 32'd0);
        tick();
        chk("mid_regrant", 32'(smp_grant), 32'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
